connect_feeder: RTL and testbench
=================================

Name: connect_feeder

Overview:
- Producer side of the fully-connected (connect) stage.
- Collects one pooled 3-channel 3x3 window (27 int8 bytes) from a byte stream.
- For each of NUM_OUT output neurons, fetches that neuron's 27 int8 weights from weight memory.
- Presents the pair as packed 216-bit vectors, with in_vld held for a fixed compute window, to the downstream 3x3 MAC / requantise block.

Parameters:
- NUM_OUT, 10, number of output neurons fired per pooled window.
- COMPUTE_CYCLES, 10, cycles in_vld is held high per neuron; must be >= 1.
- W_AW, 9, weight-memory address width; must satisfy 2^W_AW >= NUM_OUT*27.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_vld  in  1  pooled-byte stream valid.
- s_data  in  8  pooled byte (signed int8).
- s_rdy  out  1  stream ready; a byte transfers when s_vld && s_rdy.
- w_ren  out  1  weight-memory read enable.
- w_addr  out  W_AW  weight address = neuron*27 + k.
- w_rdata  in  8  weight byte; valid exactly 1 cycle after the w_ren cycle.
- pool_lin  out  216  packed window; byte k at [k*8 +: 8]; k = ch*9 + pos.
- weight_lin  out  216  packed weights, same byte order as pool_lin.
- in_vld  out  1  compute-window valid to the downstream MAC.
- out_idx  out  4  neuron index currently fired (0..NUM_OUT-1).
- frame_done  out  1  one-cycle pulse after the last neuron's window.

Behaviour:
- Reset values: every output 0. FSM enters LOAD_POOL; byte counter and neuron counter are 0.
- Reset mid-operation: same as above, effective on the next edge. Partially loaded bytes are discarded. pool_lin and weight_lin are cleared to 0.

States:
- LOAD_POOL:
  - s_rdy = 1.
  - Each accepted byte is written to pool_lin byte[cnt], then cnt++.
  - s_vld low stalls with no state change.
  - On the 27th accept (cnt = 26): cnt := 0, neuron := 0, go to LOAD_W.
- LOAD_W:
  - s_rdy = 0.
  - w_ren = 1 and w_addr = neuron*27 + rcnt for rcnt = 0..26 (27 consecutive cycles).
  - Capture pipeline: one cycle after each w_ren, w_rdata is written to weight_lin byte[rcnt-1]. The capture index is registered alongside w_ren.
  - State lasts exactly 28 cycles: 27 issue cycles plus 1 drain. Then go to FIRE.
- FIRE:
  - in_vld = 1 for exactly COMPUTE_CYCLES consecutive cycles.
  - out_idx = neuron.
  - pool_lin and weight_lin are stable for the whole window.
- GAP:
  - in_vld = 0 for exactly 1 cycle.
  - If neuron == NUM_OUT-1: frame_done = 1 this cycle, neuron := 0, go to LOAD_POOL.
  - Otherwise: neuron++, go to LOAD_W.

Register and output rules:
- pool_lin is written only in LOAD_POOL and is retained across all NUM_OUT neurons.
- weight_lin is written only in LOAD_W. The previous neuron's bytes are overwritten in place, in order.
- in_vld, s_rdy, w_ren, frame_done and out_idx are registered: state-decoded and aligned to the state they belong to.
- in_vld is never high while s_rdy or w_ren is high.

Latency:
- Last pool byte accepted -> first in_vld = 29 cycles.
- Per neuron: 28 + COMPUTE_CYCLES + 1 cycles.
- Per window: 27 (min) + NUM_OUT*(29 + COMPUTE_CYCLES) cycles.

Other rules:
- Byte order is the decided contract: ch0 pos0..8, then ch1, then ch2. No reordering or sign handling; bytes pass through bit-exact.
- w_addr arithmetic is done in W_AW bits; NUM_OUT*27 - 1 must not wrap (parameter constraint above).
- Bytes offered while s_rdy = 0 are not consumed; the upstream holds them.

Test Plan:
1. Reset, stream bytes 0x01..0x1B with s_vld = 1 continuously -> pool_lin byte k = k+1. First w_ren occurs the cycle after the 27th accept, with w_addr = 0.
2. Weight memory returns (addr & 0xFF) with 1-cycle latency, NUM_OUT = 10 -> neuron 3 window has weight_lin byte k = 81+k, out_idx = 3, and in_vld high exactly 10 cycles. Exactly 10 FIRE windows occur, then frame_done pulses once.
3. Toggle s_vld 1/0 every cycle during LOAD_POOL -> 27 bytes accepted over 54 cycles, pool_lin correct, no byte duplicated or dropped.
4. Assert rst for 1 cycle after 13 bytes accepted, then send a fresh 27-byte window 0x80..0x9A -> all outputs 0 after reset, new pool_lin byte 0 = 0x80, no stale bytes remain.
5. Assert rst during FIRE of neuron 5 -> in_vld = 0 on the next cycle, frame_done never pulses for that frame, and the FSM is back in LOAD_POOL with s_rdy = 1.
6. Negative bytes: pool 0xFF and weights 0x80 for all positions -> the downstream sees pool_lin = all 0xFF and weight_lin = all 0x80, bit-exact.

Source files
------------

// File: rtl/connect_feeder_if.sv
// Handshake and data bundle between the pooled-byte stream, the weight memory,
// the feeder and the downstream MAC.
interface connect_feeder_if #(
    parameter int W_AW = 9
);
    logic              s_vld;
    logic [7:0]        s_data;
    logic              s_rdy;
    logic              w_ren;
    logic [W_AW-1:0]   w_addr;
    logic [7:0]        w_rdata;
    logic [215:0]      pool_lin;
    logic [215:0]      weight_lin;
    logic              in_vld;
    logic [3:0]        out_idx;
    logic              frame_done;

    // The feeder drives the bundle.
    modport master (
        input  s_vld, s_data, w_rdata,
        output s_rdy, w_ren, w_addr, pool_lin, weight_lin, in_vld, out_idx, frame_done
    );

    // Stream source, weight memory and MAC side.
    modport slave (
        output s_vld, s_data, w_rdata,
        input  s_rdy, w_ren, w_addr, pool_lin, weight_lin, in_vld, out_idx, frame_done
    );
endinterface

// File: rtl/connect_feeder.sv
// Producer for the fully-connected stage: buffers one 27-byte pooled window, then
// for each output neuron streams its 27 weights in and holds both for the MAC.
module connect_feeder #(
    parameter int NUM_OUT        = 10,
    parameter int COMPUTE_CYCLES = 10,
    parameter int W_AW           = 9
) (
    input  logic               clk,
    input  logic               rst,
    connect_feeder_if.master   bus
);
    localparam int FC_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

    localparam logic [4:0]      LAST_BYTE        = 5'd26;
    localparam logic [4:0]      LAST_ISSUE       = 5'd26;
    localparam logic [4:0]      DRAIN_CYCLE      = 5'd27;
    localparam logic [3:0]      LAST_NEURON      = 4'(NUM_OUT - 1);
    localparam logic [FC_W-1:0] LAST_FIRE        = FC_W'(COMPUTE_CYCLES - 1);
    localparam logic [W_AW-1:0] BYTES_PER_NEURON = W_AW'(27);

    typedef enum logic [1:0] {
        LOAD_POOL,
        LOAD_W,
        FIRE,
        GAP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [4:0]        r_byte_cnt;
    logic [4:0]        w_byte_cnt_nxt;
    logic [4:0]        r_rcnt;
    logic [4:0]        w_rcnt_nxt;
    logic [FC_W-1:0]   r_fire_cnt;
    logic [FC_W-1:0]   w_fire_cnt_nxt;
    logic [3:0]        r_neuron;
    logic [3:0]        w_neuron_nxt;

    logic              r_s_rdy;
    logic              r_w_ren;
    logic [W_AW-1:0]   r_w_addr;
    logic              r_in_vld;
    logic [3:0]        r_out_idx;
    logic              r_frame_done;

    logic              w_s_rdy_nxt;
    logic              w_w_ren_nxt;
    logic [W_AW-1:0]   w_w_addr_nxt;
    logic              w_in_vld_nxt;
    logic [3:0]        w_out_idx_nxt;
    logic              w_frame_done_nxt;

    logic              r_cap_vld;
    logic [4:0]        r_cap_idx;
    logic [215:0]      r_pool_lin;
    logic [215:0]      r_weight_lin;

    logic              w_accept;

    assign w_accept = bus.s_vld & r_s_rdy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD_POOL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_rcnt_nxt     = r_rcnt;
        w_fire_cnt_nxt = r_fire_cnt;
        w_neuron_nxt   = r_neuron;

        case (r_state)
            LOAD_POOL: begin
                if (w_accept) begin
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_byte_cnt_nxt = '0;
                        w_neuron_nxt   = '0;
                        w_rcnt_nxt     = '0;
                        w_state_nxt    = LOAD_W;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 5'd1;
                    end
                end
            end
            LOAD_W: begin
                if (r_rcnt == DRAIN_CYCLE) begin
                    w_rcnt_nxt     = '0;
                    w_fire_cnt_nxt = '0;
                    w_state_nxt    = FIRE;
                end else begin
                    w_rcnt_nxt = r_rcnt + 5'd1;
                end
            end
            FIRE: begin
                if (r_fire_cnt == LAST_FIRE) begin
                    w_fire_cnt_nxt = '0;
                    w_state_nxt    = GAP;
                end else begin
                    w_fire_cnt_nxt = r_fire_cnt + FC_W'(1);
                end
            end
            GAP: begin
                w_rcnt_nxt = '0;
                if (r_neuron == LAST_NEURON) begin
                    w_neuron_nxt = '0;
                    w_state_nxt  = LOAD_POOL;
                end else begin
                    w_neuron_nxt = r_neuron + 4'd1;
                    w_state_nxt  = LOAD_W;
                end
            end
            default: w_state_nxt = LOAD_POOL;
        endcase
    end

    // Outputs are decoded from the next state so each registered strobe lines up with its state.
    always_comb begin
        w_s_rdy_nxt      = (w_state_nxt == LOAD_POOL);
        w_w_ren_nxt      = (w_state_nxt == LOAD_W) && (w_rcnt_nxt <= LAST_ISSUE);
        w_w_addr_nxt     = '0;
        if (w_w_ren_nxt) begin
            w_w_addr_nxt = W_AW'(w_neuron_nxt) * BYTES_PER_NEURON + W_AW'(w_rcnt_nxt);
        end
        w_in_vld_nxt     = (w_state_nxt == FIRE);
        w_out_idx_nxt    = w_in_vld_nxt ? w_neuron_nxt : 4'd0;
        w_frame_done_nxt = (w_state_nxt == GAP) && (w_neuron_nxt == LAST_NEURON);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt   <= '0;
            r_rcnt       <= '0;
            r_fire_cnt   <= '0;
            r_neuron     <= '0;
            r_s_rdy      <= 1'b0;
            r_w_ren      <= 1'b0;
            r_w_addr     <= '0;
            r_in_vld     <= 1'b0;
            r_out_idx    <= '0;
            r_frame_done <= 1'b0;
            r_cap_vld    <= 1'b0;
            r_cap_idx    <= '0;
            r_pool_lin   <= '0;
            r_weight_lin <= '0;
        end else begin
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_rcnt       <= w_rcnt_nxt;
            r_fire_cnt   <= w_fire_cnt_nxt;
            r_neuron     <= w_neuron_nxt;
            r_s_rdy      <= w_s_rdy_nxt;
            r_w_ren      <= w_w_ren_nxt;
            r_w_addr     <= w_w_addr_nxt;
            r_in_vld     <= w_in_vld_nxt;
            r_out_idx    <= w_out_idx_nxt;
            r_frame_done <= w_frame_done_nxt;

            // Read data returns one cycle after the issue, so the byte slot travels with it.
            r_cap_vld    <= r_w_ren;
            r_cap_idx    <= r_rcnt;

            if (r_state == LOAD_POOL && w_accept) begin
                r_pool_lin[{r_byte_cnt, 3'b000} +: 8] <= bus.s_data;
            end
            if (r_state == LOAD_W && r_cap_vld) begin
                r_weight_lin[{r_cap_idx, 3'b000} +: 8] <= bus.w_rdata;
            end
        end
    end

    assign bus.s_rdy      = r_s_rdy;
    assign bus.w_ren      = r_w_ren;
    assign bus.w_addr     = r_w_addr;
    assign bus.in_vld     = r_in_vld;
    assign bus.out_idx    = r_out_idx;
    assign bus.frame_done = r_frame_done;
    assign bus.pool_lin   = r_pool_lin;
    assign bus.weight_lin = r_weight_lin;
endmodule

// File: tb/tb_connect_feeder.sv
// Scoreboard bench for connect_feeder: stimulus queues the expected neuron windows,
// a negedge monitor pops and compares them whenever in_vld opens a window.
module tb_connect_feeder;
    localparam int NUM_OUT = 10;
    localparam int CC      = 10;
    localparam int W_AW    = 9;

    typedef struct {
        logic [215:0] pool;
        logic [215:0] wt;
        logic [3:0]   idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    connect_feeder_if #(.W_AW(W_AW)) bus ();

    connect_feeder #(
        .NUM_OUT(NUM_OUT),
        .COMPUTE_CYCLES(CC),
        .W_AW(W_AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] wmem [512];
    logic [7:0] pb   [27];
    exp_t       exp_q[$];
    exp_t       cur;
    int         checks   = 0;
    int         errors   = 0;
    int         frames   = 0;
    int         win_seen = 0;
    int         run_len  = 0;
    bit         in_win   = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s got=timeout want=event", name);
    endtask

    // Reference: neuron n sees the buffered window and weights at addresses n*27+k.
    function automatic exp_t make_exp(input int n);
        exp_t e;
        for (int k = 0; k < 27; k++) begin
            e.pool[k*8 +: 8] = pb[k];
            e.wt[k*8 +: 8]   = wmem[n*27 + k];
        end
        e.idx = 4'(n);
        return e;
    endfunction

    // Weight memory: one-cycle read latency.
    initial begin
        bus.w_rdata = 8'h00;
        forever begin
            @(posedge clk);
            if (bus.w_ren === 1'b1) bus.w_rdata <= wmem[bus.w_addr];
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_win   = 1'b0;
                run_len  = 0;
                win_seen = 0;
            end else begin
                if (bus.in_vld) begin
                    check("excl_rdy_ren", {bus.s_rdy, bus.w_ren}, 2'b00);
                    if (!in_win) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_window got=idx%0d want=none", bus.out_idx);
                            cur.pool = bus.pool_lin;
                            cur.wt   = bus.weight_lin;
                            cur.idx  = bus.out_idx;
                        end else begin
                            cur = exp_q.pop_front();
                        end
                        check("out_idx", bus.out_idx, cur.idx);
                        in_win  = 1'b1;
                        run_len = 0;
                    end
                    run_len++;
                    check("win_data", {bus.pool_lin, bus.weight_lin}, {cur.pool, cur.wt});
                end else if (in_win) begin
                    check("fire_len", run_len, CC);
                    in_win = 1'b0;
                    win_seen++;
                end
                if (bus.frame_done) begin
                    check("frame_windows", win_seen, NUM_OUT);
                    win_seen = 0;
                    frames++;
                end
            end
        end
    end

    task automatic check_zero();
        check("rst_pool",  bus.pool_lin, 216'd0);
        check("rst_wt",    bus.weight_lin, 216'd0);
        check("rst_ctrl",  {bus.s_rdy, bus.w_ren, bus.in_vld, bus.frame_done}, 4'd0);
        check("rst_addr",  {bus.w_addr, bus.out_idx}, '0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero();
    endtask

    // mode 0: continuous valid, 1: toggling valid, 2: random valid.
    task automatic send(input int n, input int mode);
        int   i   = 0;
        int   cyc = 0;
        int   lat;
        logic rdy;
        while (i < n && cyc < 1000) begin
            case (mode)
                0:       bus.s_vld = 1'b1;
                1:       bus.s_vld = (cyc % 2 == 0);
                default: bus.s_vld = ($urandom_range(0, 3) != 0);
            endcase
            bus.s_data = pb[i];
            rdy = bus.s_rdy;
            @(posedge clk);
            #1;
            if (bus.s_vld && rdy) i++;
            cyc++;
        end
        bus.s_vld = 1'b0;
        if (i < n) begin
            fail_now("send_accept");
            return;
        end
        if (n == 27) begin
            for (int j = 0; j < NUM_OUT; j++) exp_q.push_back(make_exp(j));
            check("first_wren", bus.w_ren, 1'b1);
            check("first_waddr", bus.w_addr, 9'd0);
            lat = 1;
            while (!bus.in_vld && lat < 200) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("fire_latency", lat, 29);
        end
    endtask

    task automatic wait_frame();
        int k = 0;
        while (!bus.frame_done && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!bus.frame_done) fail_now("frame_done_wait");
    endtask

    initial begin
        int k;
        bus.s_vld  = 1'b0;
        bus.s_data = 8'h00;
        reset_dut();

        // Ramp window with address-derived weights.
        for (int a = 0; a < 512; a++) wmem[a] = 8'(a & 8'hFF);
        for (int i = 0; i < 27; i++) pb[i] = 8'(i + 1);
        send(27, 0);
        wait_frame();

        // Toggling valid with random data.
        for (int a = 0; a < 512; a++) wmem[a] = 8'($urandom);
        for (int i = 0; i < 27; i++) pb[i] = 8'($urandom);
        send(27, 1);
        wait_frame();

        // Reset after a partial window, then a fresh window.
        for (int i = 0; i < 27; i++) pb[i] = 8'($urandom);
        send(13, 0);
        reset_dut();
        for (int i = 0; i < 27; i++) pb[i] = 8'(8'h80 + i);
        send(27, 0);
        wait_frame();

        // Reset while neuron 5 is firing.
        for (int i = 0; i < 27; i++) pb[i] = 8'($urandom);
        send(27, 0);
        k = 0;
        while (!(bus.in_vld && bus.out_idx == 4'd5) && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 1000) fail_now("neuron5_wait");
        reset_dut();
        @(posedge clk);
        #1;
        check("post_rst_rdy", {bus.s_rdy, bus.in_vld, bus.frame_done}, 3'b100);

        // Negative bytes pass through bit-exact.
        for (int a = 0; a < 512; a++) wmem[a] = 8'h80;
        for (int i = 0; i < 27; i++) pb[i] = 8'hFF;
        send(27, 0);
        wait_frame();

        // Random frames with random stream stalls.
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < 512; a++) wmem[a] = 8'($urandom);
            for (int i = 0; i < 27; i++) pb[i] = 8'($urandom);
            send(27, 2);
            wait_frame();
        end

        repeat (3) @(posedge clk);
        #1;
        check("frame_count", frames, 6);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog got=running want=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
